piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parametrised parallel-in/serial-out serializer; next generation of the 8-bit parallel2serial.
//  Adds a valid/ready input handshake, a one-word holding buffer for gapless back-to-back frames,
//  selectable bit order, a bit-period divider and a programmable inter-frame gap.
//  Sits between a word producer (CPU/AXI-lite regs, FIFO) and a single-wire serial link.
// PARAMETERS
//  WIDTH      8  bits per frame (>=2)
//  MSB_FIRST  1  1: bit WIDTH-1 sent first; 0: bit 0 sent first
//  DIV        1  clk cycles per serial bit (>=1)
//  IDLE_GAP   0  idle bit-periods inserted between consecutive frames (>=0)
// PORTS
//  clk           in   1      single clock, all logic on posedge
//  rst           in   1      asynchronous, active-high reset
//  in_valid      in   1      parallel_in holds a word
//  in_ready      out  1      holding buffer empty; word accepted on edge with in_valid&in_ready
//  parallel_in   in   WIDTH  word to serialize
//  serial_valid  out  1      serial_out carries a data bit this cycle
//  serial_out    out  1      serial data, 0 when not valid
//  serial_start  out  1      high for the whole first bit-period of a frame
//  serial_end    out  1      high for the whole last bit-period of a frame
//  busy          out  1      FSM not IDLE or holding buffer full
// BEHAVIOUR
//  Reset (async, immediate): all outputs 0 except in_ready=1; FSM=IDLE; holding buffer empty;
//   shift reg, bit/div/gap counters cleared. Reset mid-frame aborts frame, no end pulse.
//  Holding buffer: loaded on accept edge; in_ready = !hold_full (registered, no comb path from in_valid).
//  FSM states IDLE, SHIFT, GAP:
//   IDLE : if hold_full at edge -> load shifter from buffer, clear buffer, bit_cnt=0, div_cnt=0 -> SHIFT.
//   SHIFT: each bit held DIV cycles (div_cnt 0..DIV-1). At last cycle of last bit (bit_cnt=WIDTH-1):
//          IDLE_GAP>0 -> GAP; else if hold_full -> reload shifter (gapless), stay SHIFT; else -> IDLE.
//   GAP  : IDLE_GAP*DIV cycles with serial_valid=0; on final gap cycle: hold_full -> load, SHIFT; else IDLE.
//  Latency: word accepted at edge N while IDLE -> loaded at edge N+1 -> first bit on serial_out
//   during cycle after edge N+1; serial_start/serial_valid rise together with it.
//  Accept and load on the same edge allowed: buffer refills with new word while old moves to shifter.
//  serial_out/start/end/valid are registered outputs, mutually aligned; start and end never both high
//   (WIDTH>=2). Gapless case: serial_end of frame k in cycle t, serial_start of frame k+1 in cycle t+1.
//  Counters sized $clog2 of their range (min 1 bit); no wrap beyond terminal counts.
//  in_valid while in_ready=0: word ignored, producer must hold it (no drop flag).
// STRUCTURE
//  Shared package piso_pkg: state encoding localparams (ST_IDLE/ST_SHIFT/ST_GAP), clog2-width helper.
//  One sub-module natural: piso_bit_timer (div_cnt + bit tick, params DIV), reused by future deserializer.
//  Top holds buffer, shifter, FSM, gap counter; all registers on posedge clk / posedge rst.
// TESTING
//  1 WIDTH=8,MSB_FIRST=1,DIV=1: send 8'hD3 -> serial_out 1,1,0,1,0,0,1,1 over 8 cycles,
//    start in cycle 1 of frame only, end in cycle 8 only, valid 8 cycles, first bit 2 edges after accept.
//  2 MSB_FIRST=0: send 8'hD3 -> 1,1,0,0,1,0,1,1; start/end framing as in 1.
//  3 Back-to-back 8'hD3 then 8'h5A, IDLE_GAP=0: 16 contiguous valid bits, end/start on adjacent
//    cycles; second word accepted during first frame (in_ready drops 1 cycle, rises after load).
//  4 DIV=3, IDLE_GAP=2, two words: each bit held 3 cycles, start/end high 3 cycles,
//    exactly 6 cycles of serial_valid=0 between frames.
//  5 Assert rst at bit 4 of 8'hFF, deassert, send 8'h81: outputs 0 immediately, in_ready=1,
//    next frame 1,0,0,0,0,0,0,1 with clean start; no stale bits from aborted frame.
//  6 WIDTH=12, in_valid held with 3 words while busy: no word lost/duplicated, order preserved.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared definitions for the PISO serializer family: FSM state encoding and
// a counter-width helper.
package piso_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_GAP   = 2'd2;

  // Bits needed for a counter covering 0..range_n-1, never less than one bit.
  function automatic int cnt_width(input int range_n);
    if (range_n <= 2) begin
      return 1;
    end else begin
      return $clog2(range_n);
    end
  endfunction

endpackage

// File: rtl/piso_bit_timer.sv
// Bit-period divider: counts DIV clocks per serial bit and flags the last one.
module piso_bit_timer
  import piso_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic bit_tick
);

  localparam int DW = cnt_width(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  assign bit_tick = run && (div_cnt_q == DIV_LAST);

  // Next divider count: restart on frame load, wrap at the last cycle of a bit.
  always_comb begin
    div_cnt_d = div_cnt_q;
    if (clear) begin
      div_cnt_d = {DW{1'b0}};
    end else if (run) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = {DW{1'b0}};
      end else begin
        div_cnt_d = div_cnt_q + DW'(1);
      end
    end else begin
      div_cnt_d = {DW{1'b0}};
    end
  end

  // Divider count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt_q <= {DW{1'b0}};
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready input, one-word holding
// buffer, selectable bit order, bit-period divider and inter-frame gap.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int DIV       = 1,
  parameter int IDLE_GAP  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_valid,
  output logic             serial_out,
  output logic             serial_start,
  output logic             serial_end,
  output logic             busy
);

  localparam int BW      = cnt_width(WIDTH);
  localparam int GAP_CYC = IDLE_GAP * DIV;
  localparam int GW      = cnt_width(GAP_CYC);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYC > 0) ? (GAP_CYC - 1) : 0);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             valid_q, valid_d;
  logic             out_q, out_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             busy_q, busy_d;
  logic             accept_s;
  logic             load_s;
  logic             bit_tick_s;
  logic             last_bit_s;

  piso_bit_timer #(
    .DIV (DIV)
  ) u_bit_timer (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q == ST_SHIFT),
    .clear    (load_s),
    .bit_tick (bit_tick_s)
  );

  assign accept_s   = in_valid && in_ready_q;
  assign last_bit_s = bit_tick_s && (bit_cnt_q == BIT_LAST);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; load_s moves the buffered word into the shifter.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hold_full_q) begin
          state_d = ST_SHIFT;
          load_s  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_bit_s) begin
          if (IDLE_GAP > 0) begin
            state_d = ST_GAP;
          end else if (hold_full_q) begin
            state_d = ST_SHIFT;
            load_s  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (hold_full_q) begin
            state_d = ST_SHIFT;
            load_s  = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_GAP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Datapath next values: holding buffer, shifter, bit and gap counters.
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = {GW{1'b0}};

    if (accept_s) begin
      hold_d      = parallel_in;
      hold_full_d = 1'b1;
    end else if (load_s) begin
      hold_full_d = 1'b0;
    end else begin
      hold_full_d = hold_full_q;
    end

    if (load_s) begin
      shift_d   = hold_q;
      bit_cnt_d = {BW{1'b0}};
    end else if ((state_q == ST_SHIFT) && bit_tick_s) begin
      if (MSB_FIRST != 0) begin
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
      end else begin
        shift_d = {1'b0, shift_q[WIDTH-1:1]};
      end
      if (bit_cnt_q == BIT_LAST) begin
        bit_cnt_d = {BW{1'b0}};
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end else begin
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
    end

    if ((state_q == ST_GAP) && (gap_cnt_q != GAP_LAST)) begin
      gap_cnt_d = gap_cnt_q + GW'(1);
    end else begin
      gap_cnt_d = {GW{1'b0}};
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q      <= {WIDTH{1'b0}};
      hold_full_q <= 1'b0;
      shift_q     <= {WIDTH{1'b0}};
      bit_cnt_q   <= {BW{1'b0}};
      gap_cnt_q   <= {GW{1'b0}};
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
    end
  end

  // Outputs are computed from next-cycle state so the registered copies line up with the bit on the wire.
  always_comb begin
    valid_d    = (state_d == ST_SHIFT);
    in_ready_d = !hold_full_d;
    busy_d     = (state_d != ST_IDLE) || hold_full_d;
    if (valid_d) begin
      out_d   = (MSB_FIRST != 0) ? shift_d[WIDTH-1] : shift_d[0];
      start_d = (bit_cnt_d == {BW{1'b0}});
      end_d   = (bit_cnt_d == BIT_LAST);
    end else begin
      out_d   = 1'b0;
      start_d = 1'b0;
      end_d   = 1'b0;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b1;
      valid_q    <= 1'b0;
      out_q      <= 1'b0;
      start_q    <= 1'b0;
      end_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      in_ready_q <= in_ready_d;
      valid_q    <= valid_d;
      out_q      <= out_d;
      start_q    <= start_d;
      end_q      <= end_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign serial_valid = valid_q;
  assign serial_out   = out_q;
  assign serial_start = start_q;
  assign serial_end   = end_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer: four parameterisations share clock and reset.
module tb_piso_serializer;

  logic clk = 1'b0;
  logic rst;

  logic       a_iv, a_rdy, a_sv, a_so, a_ss, a_se, a_busy;
  logic [7:0] a_pin;
  logic       b_iv, b_rdy, b_sv, b_so, b_ss, b_se, b_busy;
  logic [7:0] b_pin;
  logic       c_iv, c_rdy, c_sv, c_so, c_ss, c_se, c_busy;
  logic [7:0] c_pin;
  logic        d_iv, d_rdy, d_sv, d_so, d_ss, d_se, d_busy;
  logic [11:0] d_pin;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .DIV(1), .IDLE_GAP(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_iv), .in_ready(a_rdy), .parallel_in(a_pin),
    .serial_valid(a_sv), .serial_out(a_so), .serial_start(a_ss), .serial_end(a_se), .busy(a_busy));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(0), .DIV(1), .IDLE_GAP(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_iv), .in_ready(b_rdy), .parallel_in(b_pin),
    .serial_valid(b_sv), .serial_out(b_so), .serial_start(b_ss), .serial_end(b_se), .busy(b_busy));

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1), .DIV(3), .IDLE_GAP(2)) dut_c (
    .clk(clk), .rst(rst), .in_valid(c_iv), .in_ready(c_rdy), .parallel_in(c_pin),
    .serial_valid(c_sv), .serial_out(c_so), .serial_start(c_ss), .serial_end(c_se), .busy(c_busy));

  piso_serializer #(.WIDTH(12), .MSB_FIRST(1), .DIV(1), .IDLE_GAP(0)) dut_d (
    .clk(clk), .rst(rst), .in_valid(d_iv), .in_ready(d_rdy), .parallel_in(d_pin),
    .serial_valid(d_sv), .serial_out(d_so), .serial_start(d_ss), .serial_end(d_se), .busy(d_busy));

  task automatic test_reset();
    logic [5:0] got;
    rst = 1'b1;
    a_iv = 1'b0; b_iv = 1'b0; c_iv = 1'b0; d_iv = 1'b0;
    a_pin = 8'h00; b_pin = 8'h00; c_pin = 8'h00; d_pin = 12'h000;
    repeat (3) @(negedge clk);
    got = {a_rdy, a_busy, a_sv, a_so, a_ss, a_se};
    vecs++;
    if (got !== 6'b100000) begin errs++; $display("FAIL reset_a: got %b want 100000", got); end
    got = {b_rdy, b_busy, b_sv, b_so, b_ss, b_se};
    vecs++;
    if (got !== 6'b100000) begin errs++; $display("FAIL reset_b: got %b want 100000", got); end
    got = {c_rdy, c_busy, c_sv, c_so, c_ss, c_se};
    vecs++;
    if (got !== 6'b100000) begin errs++; $display("FAIL reset_c: got %b want 100000", got); end
    got = {d_rdy, d_busy, d_sv, d_so, d_ss, d_se};
    vecs++;
    if (got !== 6'b100000) begin errs++; $display("FAIL reset_d: got %b want 100000", got); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Each loop iteration samples at the negedge, then acts as producer for the next posedge.
  task automatic test_msb_first();
    logic [7:0] w;
    logic [3:0] got, exp;
    int idx;
    w = 8'hD3;
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      got = {a_sv, a_so, a_ss, a_se};
      if (k >= 2 && k < 10) exp = {1'b1, w[7-(k-2)], (k == 2), (k == 9)};
      else exp = 4'b0000;
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL msb_first cyc %0d: got v/o/s/e %b want %b", k, got, exp); end
      if (k == 1) begin
        vecs++;
        if ({a_rdy, a_busy} !== 2'b01) begin errs++; $display("FAIL msb_first_hold: got rdy/busy %b want 01", {a_rdy, a_busy}); end
      end
      if (idx < 1) begin a_pin = w; a_iv = 1'b1; if (a_rdy) idx++; end
      else a_iv = 1'b0;
    end
    vecs++;
    if (a_busy !== 1'b0) begin errs++; $display("FAIL msb_first_idle: got busy %b want 0", a_busy); end
  endtask

  task automatic test_lsb_first();
    logic [7:0] w;
    logic [3:0] got, exp;
    int idx;
    w = 8'hD3;
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      got = {b_sv, b_so, b_ss, b_se};
      if (k >= 2 && k < 10) exp = {1'b1, w[k-2], (k == 2), (k == 9)};
      else exp = 4'b0000;
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL lsb_first cyc %0d: got v/o/s/e %b want %b", k, got, exp); end
      if (idx < 1) begin b_pin = w; b_iv = 1'b1; if (b_rdy) idx++; end
      else b_iv = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ws [2];
    logic [7:0] w;
    logic [3:0] got, exp;
    int idx, j;
    ws = '{8'hD3, 8'h5A};
    idx = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      got = {a_sv, a_so, a_ss, a_se};
      if (k >= 2 && k < 18) begin
        j = k - 2;
        w = ws[j / 8];
        exp = {1'b1, w[7 - (j % 8)], (j % 8 == 0), (j % 8 == 7)};
      end else begin
        exp = 4'b0000;
      end
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL back_to_back cyc %0d: got v/o/s/e %b want %b", k, got, exp); end
      if (k == 1 || k == 2 || k == 3 || k == 9 || k == 10) begin
        vecs++;
        if (a_rdy !== ((k == 2) || (k == 10))) begin
          errs++; $display("FAIL back_to_back_ready cyc %0d: got %b want %b", k, a_rdy, ((k == 2) || (k == 10)));
        end
      end
      if (idx < 2) begin a_pin = ws[idx]; a_iv = 1'b1; if (a_rdy) idx++; end
      else a_iv = 1'b0;
    end
  endtask

  task automatic test_div_gap();
    logic [7:0] ws [2];
    logic [7:0] w;
    logic [3:0] got, exp;
    int idx, j, bitn;
    ws = '{8'hA5, 8'h3C};
    idx = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      got = {c_sv, c_so, c_ss, c_se};
      if ((k >= 2 && k < 26) || (k >= 32 && k < 56)) begin
        j = (k < 26) ? (k - 2) : (k - 32);
        w = (k < 26) ? ws[0] : ws[1];
        bitn = j / 3;
        exp = {1'b1, w[7 - bitn], (bitn == 0), (bitn == 7)};
      end else begin
        exp = 4'b0000;
      end
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL div_gap cyc %0d: got v/o/s/e %b want %b", k, got, exp); end
      if (idx < 2) begin c_pin = ws[idx]; c_iv = 1'b1; if (c_rdy) idx++; end
      else c_iv = 1'b0;
    end
    vecs++;
    if (idx !== 2) begin errs++; $display("FAIL div_gap_accepts: got %0d want 2", idx); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] w;
    logic [3:0] got, exp;
    logic [5:0] st;
    int idx;
    w = 8'hFF;
    idx = 0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      got = {a_sv, a_so, a_ss, a_se};
      if (k >= 2) exp = {1'b1, w[7-(k-2)], (k == 2), 1'b0};
      else exp = 4'b0000;
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL abort_pre cyc %0d: got v/o/s/e %b want %b", k, got, exp); end
      if (idx < 1) begin a_pin = w; a_iv = 1'b1; if (a_rdy) idx++; end
      else a_iv = 1'b0;
    end
    rst = 1'b1;
    a_iv = 1'b0;
    #1;
    st = {a_rdy, a_busy, a_sv, a_so, a_ss, a_se};
    vecs++;
    if (st !== 6'b100000) begin errs++; $display("FAIL abort_reset: got rdy/busy/v/o/s/e %b want 100000", st); end
    @(negedge clk);
    rst = 1'b0;
    w = 8'h81;
    idx = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      got = {a_sv, a_so, a_ss, a_se};
      if (k >= 2 && k < 10) exp = {1'b1, w[7-(k-2)], (k == 2), (k == 9)};
      else exp = 4'b0000;
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL abort_post cyc %0d: got v/o/s/e %b want %b", k, got, exp); end
      if (idx < 1) begin a_pin = w; a_iv = 1'b1; if (a_rdy) idx++; end
      else a_iv = 1'b0;
    end
  endtask

  task automatic test_wide_stream();
    logic [11:0] ws [3];
    logic [11:0] w;
    logic [3:0] got, exp;
    int idx, j;
    ws = '{12'hA5C, 12'h3F1, 12'h96E};
    idx = 0;
    for (int k = 0; k < 42; k++) begin
      @(negedge clk);
      got = {d_sv, d_so, d_ss, d_se};
      if (k >= 2 && k < 38) begin
        j = k - 2;
        w = ws[j / 12];
        exp = {1'b1, w[11 - (j % 12)], (j % 12 == 0), (j % 12 == 11)};
      end else begin
        exp = 4'b0000;
      end
      vecs++;
      if (got !== exp) begin errs++; $display("FAIL wide_stream cyc %0d: got v/o/s/e %b want %b", k, got, exp); end
      if (idx < 3) begin d_pin = ws[idx]; d_iv = 1'b1; if (d_rdy) idx++; end
      else d_iv = 1'b0;
    end
    vecs++;
    if (idx !== 3) begin errs++; $display("FAIL wide_stream_accepts: got %0d want 3", idx); end
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_div_gap();
    test_reset_abort();
    test_wide_stream();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
